// File: rtl/drr_req_arbiter.sv
// drr_req_arbiter: round-robin front end that shares one DRR calc engine between
// NUM_REQ requesters, with an in-block restoring divider. Define DRR_ARB_TIMEOUT_EN for the engine watchdog.
module drr_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int CLASS_WIDTH    = 5,
    parameter int WEIGHT_WIDTH   = 16,
    parameter int PKT_WIDTH      = 16,
    parameter int RESULT_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              in_valid,
    output logic [NUM_REQ-1:0]              in_ready,
    input  logic [NUM_REQ*CLASS_WIDTH-1:0]  in_class_id,
    input  logic [NUM_REQ*WEIGHT_WIDTH-1:0] in_weight,
    input  logic [NUM_REQ*PKT_WIDTH-1:0]    in_pkt_len,
    output logic [NUM_REQ-1:0]              out_valid,
    output logic [RESULT_WIDTH-1:0]         out_data,
    output logic                            out_err,
    output logic                            eng_req_valid,
    output logic [CLASS_WIDTH-1:0]          eng_req_class_id,
    output logic [WEIGHT_WIDTH-1:0]         eng_req_class_weight,
    output logic [WEIGHT_WIDTH-1:0]         eng_req_div_quotient,
    output logic [WEIGHT_WIDTH-1:0]         eng_req_div_remain,
    input  logic                            eng_resp_valid,
    input  logic [RESULT_WIDTH-1:0]         eng_resp_data
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(PKT_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIV   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                    state_r;
    logic [IDX_W-1:0]          rr_ptr_r;
    logic [IDX_W-1:0]          grant_r;
    logic [IDX_W-1:0]          grant_idx_s;
    logic [IDX_W:0]            cand_s;
    logic                      grant_found_s;
    logic [CLASS_WIDTH-1:0]    sel_class_s;
    logic [WEIGHT_WIDTH-1:0]   sel_weight_s;
    logic [PKT_WIDTH-1:0]      sel_len_s;
    logic [CLASS_WIDTH-1:0]    class_r;
    logic [WEIGHT_WIDTH-1:0]   weight_r;
    logic [WEIGHT_WIDTH-1:0]   rem_r;
    logic [WEIGHT_WIDTH-1:0]   rem_next_s;
    logic [PKT_WIDTH-1:0]      quo_r;
    logic [PKT_WIDTH-1:0]      quo_next_s;
    logic [WEIGHT_WIDTH:0]     trial_s;
    logic                      qbit_s;
    logic [CNT_W-1:0]          bit_cnt_r;
    logic [NUM_REQ-1:0]        out_valid_r;
    logic [RESULT_WIDTH-1:0]   out_data_r;
    logic                      out_err_r;
    logic                      eng_req_valid_r;
    logic [CLASS_WIDTH-1:0]    eng_class_r;
    logic [WEIGHT_WIDTH-1:0]   eng_weight_r;
    logic [WEIGHT_WIDTH-1:0]   eng_quo_r;
    logic [WEIGHT_WIDTH-1:0]   eng_rem_r;
`ifdef DRR_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]           wait_cnt_r;
`endif

    // Round-robin search: first valid requester at or above rr_ptr_r, with wrap.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
            if (cand_s >= (IDX_W+1)'(NUM_REQ)) begin
                cand_s = cand_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_found_s && in_valid[cand_s[IDX_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Select the winning requester's request fields.
    always_comb begin
        sel_class_s  = '0;
        sel_weight_s = '0;
        sel_len_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == grant_idx_s) begin
                sel_class_s  = in_class_id[i*CLASS_WIDTH +: CLASS_WIDTH];
                sel_weight_s = in_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                sel_len_s    = in_pkt_len[i*PKT_WIDTH +: PKT_WIDTH];
            end else begin
                sel_class_s  = sel_class_s;
            end
        end
    end

    // Accept is offered only while idle and never during reset.
    always_comb begin
        in_ready = '0;
        if (!rst && (state_r == IDLE) && grant_found_s) begin
            in_ready[grant_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial_s = {rem_r, quo_r[PKT_WIDTH-1]};
        if (trial_s >= {1'b0, weight_r}) begin
            rem_next_s = WEIGHT_WIDTH'(trial_s - {1'b0, weight_r});
            qbit_s     = 1'b1;
        end else begin
            rem_next_s = trial_s[WEIGHT_WIDTH-1:0];
            qbit_s     = 1'b0;
        end
        quo_next_s = {quo_r[PKT_WIDTH-2:0], qbit_s};
    end

    // Request sequencer: accept, divide, issue, wait for engine, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            rr_ptr_r        <= '0;
            grant_r         <= '0;
            class_r         <= '0;
            weight_r        <= '0;
            rem_r           <= '0;
            quo_r           <= '0;
            bit_cnt_r       <= '0;
            out_valid_r     <= '0;
            out_data_r      <= '0;
            out_err_r       <= 1'b0;
            eng_req_valid_r <= 1'b0;
            eng_class_r     <= '0;
            eng_weight_r    <= '0;
            eng_quo_r       <= '0;
            eng_rem_r       <= '0;
`ifdef DRR_ARB_TIMEOUT_EN
            wait_cnt_r      <= '0;
`endif
        end else begin
            out_valid_r     <= '0;
            eng_req_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        grant_r   <= grant_idx_s;
                        class_r   <= sel_class_s;
                        weight_r  <= sel_weight_s;
                        quo_r     <= sel_len_s;
                        rem_r     <= '0;
                        bit_cnt_r <= '0;
                        rr_ptr_r  <= (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);
                        if (sel_weight_s == '0) begin
                            out_valid_r <= NUM_REQ'(1'b1) << grant_idx_s;
                            out_data_r  <= '0;
                            out_err_r   <= 1'b1;
                            state_r     <= RESP;
                        end else begin
                            state_r     <= DIV;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DIV: begin
                    quo_r     <= quo_next_s;
                    rem_r     <= rem_next_s;
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    if (bit_cnt_r == CNT_W'(PKT_WIDTH - 1)) begin
                        eng_req_valid_r <= 1'b1;
                        eng_class_r     <= class_r;
                        eng_weight_r    <= weight_r;
                        eng_quo_r       <= WEIGHT_WIDTH'(quo_next_s);
                        eng_rem_r       <= rem_next_s;
                        state_r         <= ISSUE;
                    end else begin
                        state_r <= DIV;
                    end
                end
                ISSUE: begin
`ifdef DRR_ARB_TIMEOUT_EN
                    wait_cnt_r <= '0;
`endif
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (eng_resp_valid) begin
                        out_valid_r <= NUM_REQ'(1'b1) << grant_r;
                        out_data_r  <= eng_resp_data;
                        out_err_r   <= 1'b0;
                        state_r     <= RESP;
`ifdef DRR_ARB_TIMEOUT_EN
                    end else if (wait_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        out_valid_r <= NUM_REQ'(1'b1) << grant_r;
                        out_data_r  <= '0;
                        out_err_r   <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        wait_cnt_r  <= wait_cnt_r + TO_W'(1);
                        state_r     <= WAIT;
                    end
`else
                    end else begin
                        state_r     <= WAIT;
                    end
`endif
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign out_valid            = out_valid_r;
    assign out_data             = out_data_r;
    assign out_err              = out_err_r;
    assign eng_req_valid        = eng_req_valid_r;
    assign eng_req_class_id     = eng_class_r;
    assign eng_req_class_weight = eng_weight_r;
    assign eng_req_div_quotient = eng_quo_r;
    assign eng_req_div_remain   = eng_rem_r;

endmodule

// File: tb/tb_drr_req_arbiter.sv
// Randomized bench for drr_req_arbiter: per-requester queues, an engine model and
// a transaction-level reference computing grants, quotients and latencies from arithmetic.
module tb_drr_req_arbiter;
    localparam int NR = 4;
    localparam int CW = 5;
    localparam int WW = 16;
    localparam int PW = 16;
    localparam int RW = 32;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     in_valid;
    logic [NR-1:0]     in_ready;
    logic [NR*CW-1:0]  in_class_id;
    logic [NR*WW-1:0]  in_weight;
    logic [NR*PW-1:0]  in_pkt_len;
    logic [NR-1:0]     out_valid;
    logic [RW-1:0]     out_data;
    logic              out_err;
    logic              eng_req_valid;
    logic [CW-1:0]     eng_req_class_id;
    logic [WW-1:0]     eng_req_class_weight;
    logic [WW-1:0]     eng_req_div_quotient;
    logic [WW-1:0]     eng_req_div_remain;
    logic              eng_resp_valid;
    logic [RW-1:0]     eng_resp_data;

    drr_req_arbiter #(
        .NUM_REQ(NR), .CLASS_WIDTH(CW), .WEIGHT_WIDTH(WW), .PKT_WIDTH(PW),
        .RESULT_WIDTH(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class_id(in_class_id), .in_weight(in_weight), .in_pkt_len(in_pkt_len),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
        .eng_req_valid(eng_req_valid), .eng_req_class_id(eng_req_class_id),
        .eng_req_class_weight(eng_req_class_weight),
        .eng_req_div_quotient(eng_req_div_quotient),
        .eng_req_div_remain(eng_req_div_remain),
        .eng_resp_valid(eng_resp_valid), .eng_resp_data(eng_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] cls;
        logic [WW-1:0] w;
        logic [PW-1:0] len;
    } req_t;

    typedef struct packed {
        int idx;
        int cyc;
    } grant_t;

    req_t     rq [NR][$];
    grant_t   glog[$];
    int       n_tests = 0;
    int       n_fail = 0;
    int       cyc = 0;
    logic     rst_next;
    int       m_rr, free_cyc, exp_issue_cyc, exp_out_cyc, exp_grant, resp_cyc;
    logic [WW-1:0] exp_q, exp_r, exp_w;
    logic [CW-1:0] exp_cls;
    logic          exp_err;
    logic [RW-1:0] exp_data, resp_data, force_data;
    logic          eng_mute, force_data_en, acc_pending;
    int            acc_idx;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Compare this cycle's outputs with the reference and advance the reference.
    task automatic check_cycle();
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_ov;
        int g;
        req_t h;
        exp_ready = '0;
        g = -1;
        if (!rst && cyc >= free_cyc) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && in_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq("in_ready", in_ready, exp_ready);
        check_eq("eng_req_valid", eng_req_valid, cyc == exp_issue_cyc);
        if (cyc == exp_issue_cyc) begin
            check_eq("eng_class", eng_req_class_id, exp_cls);
            check_eq("eng_weight", eng_req_class_weight, exp_w);
            check_eq("eng_quotient", eng_req_div_quotient, exp_q);
            check_eq("eng_remain", eng_req_div_remain, exp_r);
            if (!eng_mute) begin
                resp_cyc  = cyc + 3;
                resp_data = force_data_en ? force_data : $urandom;
                exp_data  = resp_data;
                force_data_en = 1'b0;
            end
        end
        exp_ov = (cyc == exp_out_cyc) ? (NR'(1) << exp_grant) : '0;
        check_eq("out_valid", out_valid, exp_ov);
        if (cyc == exp_out_cyc) begin
            check_eq("out_data", out_data, exp_data);
            check_eq("out_err", out_err, exp_err);
        end
        if (rst) begin
            m_rr = 0; free_cyc = cyc + 1;
            exp_issue_cyc = -1; exp_out_cyc = -1; resp_cyc = -1;
        end else if (g >= 0) begin
            h = rq[g][0];
            acc_pending = 1'b1;
            acc_idx = g;
            exp_grant = g;
            m_rr = (g + 1) % NR;
            glog.push_back(grant_t'{idx: g, cyc: cyc});
            exp_cls = h.cls;
            exp_w = h.w;
            if (h.w == '0) begin
                exp_err = 1'b1; exp_data = '0;
                exp_issue_cyc = -1; exp_out_cyc = cyc + 1; free_cyc = cyc + 2;
            end else begin
                exp_q = WW'(int'(h.len) / int'(h.w));
                exp_r = WW'(int'(h.len) % int'(h.w));
                exp_issue_cyc = cyc + PW + 1;
                if (eng_mute) begin
                    exp_err = 1'b1; exp_data = '0;
                    exp_out_cyc = cyc + PW + 2 + TO;
                end else begin
                    exp_err = 1'b0;
                    exp_out_cyc = cyc + PW + 5;
                end
                free_cyc = exp_out_cyc + 1;
            end
        end
    endtask

    // One clock: retire last accept, drive inputs at the falling edge, then check.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (acc_pending) begin
            void'(rq[acc_idx].pop_front());
            acc_pending = 1'b0;
        end
        rst = rst_next;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                in_valid[i] = 1'b1;
                in_class_id[i*CW +: CW] = rq[i][0].cls;
                in_weight[i*WW +: WW]   = rq[i][0].w;
                in_pkt_len[i*PW +: PW]  = rq[i][0].len;
            end else begin
                in_valid[i] = 1'b0;
                in_class_id[i*CW +: CW] = CW'($urandom);
                in_weight[i*WW +: WW]   = WW'($urandom);
                in_pkt_len[i*PW +: PW]  = PW'($urandom);
            end
        end
        eng_resp_valid = (cyc == resp_cyc);
        eng_resp_data  = (cyc == resp_cyc) ? resp_data : $urandom;
        #1;
        check_cycle();
    endtask

    function automatic bit work_left();
        bit any = acc_pending;
        for (int i = 0; i < NR; i++) if (rq[i].size() > 0) any = 1'b1;
        return any;
    endfunction

    task automatic drain();
        int guard = 0;
        while ((work_left() || cyc < free_cyc) && guard < 5000) begin
            tick();
            guard++;
        end
        check_eq("drain_bound", guard >= 5000, 1'b0);
    endtask

    initial begin
        int t0, gd;
        m_rr = 0; free_cyc = 0; exp_issue_cyc = -1; exp_out_cyc = -1; resp_cyc = -1;
        exp_grant = 0; exp_err = 1'b0; exp_data = '0; exp_q = '0; exp_r = '0; exp_w = '0; exp_cls = '0;
        resp_data = '0; force_data = '0; force_data_en = 1'b0; eng_mute = 1'b0;
        acc_pending = 1'b0; acc_idx = 0;
        rst = 1'b1; rst_next = 1'b1;
        in_valid = '0; in_class_id = '0; in_weight = '0; in_pkt_len = '0;
        eng_resp_valid = 1'b0; eng_resp_data = '0;

        repeat (3) tick();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_err", out_err, 0);
        check_eq("rst_eng_class", eng_req_class_id, 0);
        check_eq("rst_eng_weight", eng_req_class_weight, 0);
        check_eq("rst_eng_quo", eng_req_div_quotient, 0);
        check_eq("rst_eng_rem", eng_req_div_remain, 0);
        rst_next = 1'b0;

        // single request with a known engine result
        force_data_en = 1'b1;
        force_data = 32'hA000_1000;
        rq[0].push_back(req_t'{cls: 5'd3, w: 16'd100, len: 16'd1500});
        drain();

        // reset during DIV drops the request and restarts round-robin at 0
        glog.delete();
        rq[1].push_back(req_t'{cls: 5'd9, w: 16'd10, len: 16'd1000});
        rq[3].push_back(req_t'{cls: 5'd4, w: 16'd3, len: 16'd77});
        gd = 0;
        while (glog.size() == 0 && gd < 50) begin tick(); gd++; end
        check_eq("rst_pre_grant_seen", glog.size() > 0, 1'b1);
        check_eq("rst_pre_grant_idx", (glog.size() > 0) ? glog[0].idx : -1, 1);
        t0 = (glog.size() > 0) ? glog[0].cyc : cyc;
        rq[0].push_back(req_t'{cls: 5'd1, w: 16'd5, len: 16'd40});
        while (cyc < t0 + 7) tick();
        rst_next = 1'b1;
        tick();
        rst_next = 1'b0;
        tick();
        check_eq("mid_rst_eng_class", eng_req_class_id, 0);
        check_eq("mid_rst_eng_quo", eng_req_div_quotient, 0);
        drain();
        check_eq("rst_post_grant_idx", (glog.size() > 1) ? glog[1].idx : -1, 0);

        // all four requesters competing
        glog.delete();
        for (int i = 0; i < NR; i++) rq[i].push_back(req_t'{cls: CW'(i + 10), w: 16'd3, len: PW'(200 + i)});
        rq[0].push_back(req_t'{cls: 5'd20, w: 16'd9, len: 16'd999});
        drain();
        check_eq("rr_count", glog.size(), 5);
        for (int k = 0; k < 5 && k < glog.size(); k++) begin
            check_eq("rr_order", glog[k].idx, (k == 4) ? 0 : k);
            if (k > 0) check_eq("rr_spacing", glog[k].cyc - glog[k-1].cyc, PW + 6);
        end

        // divider corners and zero weight
        rq[1].push_back(req_t'{cls: 5'd2, w: 16'd1500, len: 16'd100});
        rq[2].push_back(req_t'{cls: 5'd6, w: 16'd1, len: 16'hFFFF});
        rq[3].push_back(req_t'{cls: 5'd7, w: 16'd7, len: 16'd50});
        rq[0].push_back(req_t'{cls: 5'd8, w: 16'd9, len: 16'd0});
        drain();
        rq[2].push_back(req_t'{cls: 5'd11, w: 16'd0, len: 16'd321});
        drain();

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                req_t r;
                int sel;
                sel = $urandom_range(0, 7);
                r.cls = CW'($urandom);
                r.w = (sel == 0) ? 16'd0 : (sel == 1) ? 16'd1 : (sel < 5) ? WW'($urandom_range(1, 64)) : WW'($urandom_range(1, 65535));
                r.len = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 40)) : PW'($urandom);
                rq[$urandom_range(0, NR - 1)].push_back(r);
            end
            tick();
        end
        drain();

`ifdef DRR_ARB_TIMEOUT_EN
        // silent engine: watchdog answers with an error, later strobe is ignored
        eng_mute = 1'b1;
        rq[1].push_back(req_t'{cls: 5'd5, w: 16'd4, len: 16'd123});
        drain();
        eng_mute = 1'b0;
        resp_cyc = cyc + 2;
        resp_data = 32'hDEAD_BEEF;
        repeat (6) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
